// File: rtl/fetch_prefetch_q.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_q
// Description : LEGv8 fetch stage with a prefetch queue. The stage holds the
//               PC and issues req/gnt requests to a variable-latency
//               instruction memory that returns words in order. Up to MAX_OUT
//               requests can be in flight at once. Returned words are stored
//               with their PC in a DEPTH-entry queue, which decode drains
//               through a valid/ready handshake.
//               When PCSrc_F is high, the stage redirects to PCBranch_F,
//               flushes the queue and discards stale in-flight responses.
//               Optional macro FETCH_PERF_CNT_EN adds the stall_cnt_F and
//               flush_cnt_F performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_q #(
    parameter int             N        = 64,
    parameter int             DEPTH    = 4,
    parameter int             MAX_OUT  = 2,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrc_F,
    input  logic [N-1:0]  PCBranch_F,
    output logic          imem_req_F,
    output logic [N-1:0]  imem_addr_F,
    input  logic          imem_gnt_F,
    input  logic          imem_rvalid_F,
    input  logic [31:0]   imem_rdata_F,
    output logic          instr_valid_D,
    output logic [31:0]   instr_D,
    output logic [N-1:0]  pc_D,
    input  logic          instr_ready_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt_F,
    output logic [31:0]   flush_cnt_F
`endif
);

    localparam int c_QW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int c_OW = $clog2(MAX_OUT + 1);
    localparam int c_SW = ((c_CW > c_OW) ? c_CW : c_OW) + 1;

    logic [N-1:0]      r_pc;
    logic [31:0]       r_q_instr [DEPTH];
    logic [N-1:0]      r_q_pc    [DEPTH];
    logic [c_QW-1:0]   r_q_rd;
    logic [c_QW-1:0]   r_q_wr;
    logic [c_CW-1:0]   r_count;
    logic [N-1:0]      r_if_pc   [MAX_OUT];
    logic [c_IW-1:0]   r_if_rd;
    logic [c_IW-1:0]   r_if_wr;
    logic [c_OW-1:0]   r_out;
    logic [c_OW-1:0]   r_drop;

    logic w_credit;
    logic w_req;
    logic w_gnt;
    logic w_rv;
    logic w_push;
    logic w_discard;
    logic w_pop;

    // The in-flight PC FIFO need not be a power of 2, so its pointers wrap explicitly.
    function automatic logic [c_IW-1:0] f_if_inc(input logic [c_IW-1:0] p);
        return (p == c_IW'(MAX_OUT - 1)) ? '0 : p + c_IW'(1);
    endfunction

    // Words already queued plus requests still in flight must never exceed the queue size.
    // This credit check is what prevents the queue from overflowing.
    assign w_credit  = (c_SW'(r_count) + c_SW'(r_out)) < c_SW'(DEPTH);
    assign w_req     = reset & ~PCSrc_F & w_credit & (r_out < c_OW'(MAX_OUT));
    assign w_gnt     = w_req & imem_gnt_F;
    // A response that arrives while nothing is outstanding is a stray left over from before reset.
    assign w_rv      = imem_rvalid_F & (r_out != '0);
    assign w_discard = w_rv & ~PCSrc_F & (r_drop != '0);
    assign w_push    = w_rv & ~PCSrc_F & (r_drop == '0);
    assign w_pop     = (r_count != '0) & instr_ready_D;

    assign imem_req_F    = w_req;
    assign imem_addr_F   = r_pc;
    assign instr_valid_D = (r_count != '0);
    assign instr_D       = r_q_instr[r_q_rd];
    assign pc_D          = r_q_pc[r_q_rd];

    // Request side: PC, in-flight PC FIFO, outstanding and drop counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_if_rd <= '0;
            r_if_wr <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                r_if_pc[i] <= '0;
            end
        end else if (PCSrc_F) begin
            // No request goes out in a redirect cycle. Every response still owed
            // after this cycle is stale and must be dropped.
            r_pc    <= PCBranch_F;
            r_if_rd <= '0;
            r_if_wr <= '0;
            r_out   <= r_out - c_OW'(w_rv);
            r_drop  <= r_out - c_OW'(w_rv);
        end else begin
            if (w_gnt) begin
                r_pc             <= r_pc + N'(4);
                r_if_pc[r_if_wr] <= r_pc;
                r_if_wr          <= f_if_inc(r_if_wr);
            end
            if (w_push) begin
                r_if_rd <= f_if_inc(r_if_rd);
            end
            if (w_discard) begin
                r_drop <= r_drop - c_OW'(1);
            end
            if (w_gnt && !w_rv) begin
                r_out <= r_out + c_OW'(1);
            end else if (!w_gnt && w_rv) begin
                r_out <= r_out - c_OW'(1);
            end
        end
    end

    // Instruction queue: push returned words together with their PC, and pop on the decode handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (PCSrc_F) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_instr[r_q_wr] <= imem_rdata_F;
                r_q_pc[r_q_wr]    <= r_if_pc[r_if_rd];
                r_q_wr            <= r_q_wr + c_QW'(1);
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + c_QW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counters: cycles with an empty queue, and redirect cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_count == '0) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (PCSrc_F && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_F = r_stall_cnt;
    assign flush_cnt_F = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_q
// Description : Self-checking bench for fetch_prefetch_q. It models an
//               in-order instruction memory and uses a scoreboard of
//               expected {pc, instr} pairs. A second instance is built with
//               N=8 and RESET_PC=0xFC to check that the PC wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_q;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pcsrc;
    logic [63:0] branch;
    logic        req;
    logic [63:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        ready;

    logic        s_rst_n;
    logic        s_req;
    logic [7:0]  s_addr;
    logic        s_rv;
    logic [31:0] s_rd;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [7:0]  s_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] s_stall_cnt;
    logic [31:0] s_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_q dut (
        .clk           (clk),
        .reset         (reset_n),
        .PCSrc_F       (pcsrc),
        .PCBranch_F    (branch),
        .imem_req_F    (req),
        .imem_addr_F   (addr),
        .imem_gnt_F    (gnt),
        .imem_rvalid_F (rvalid),
        .imem_rdata_F  (rdata),
        .instr_valid_D (valid),
        .instr_D       (instr),
        .pc_D          (pc),
        .instr_ready_D (ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_F   (stall_cnt),
        .flush_cnt_F   (flush_cnt)
`endif
    );

    fetch_prefetch_q #(.N(8), .DEPTH(4), .MAX_OUT(2), .RESET_PC(8'hFC)) dut_small (
        .clk           (clk),
        .reset         (s_rst_n),
        .PCSrc_F       (1'b0),
        .PCBranch_F    (8'h00),
        .imem_req_F    (s_req),
        .imem_addr_F   (s_addr),
        .imem_gnt_F    (1'b1),
        .imem_rvalid_F (s_rv),
        .imem_rdata_F  (s_rd),
        .instr_valid_D (s_valid),
        .instr_D       (s_instr),
        .pc_D          (s_pc),
        .instr_ready_D (1'b1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_F   (s_stall_cnt),
        .flush_cnt_F   (s_flush_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Imem model and scoreboard state
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [95:0] exp_q[$];
    logic [63:0] pop_pc[$];
    int          pop_cyc[$];
    logic [63:0] exp_pc;
    int          cyc;
    int          last_due;
    int          lat;
    int          stall_exp;
    int          flush_exp;
    logic        gnt_en;
    logic        ready_en;
    logic        redir_now;
    logic [63:0] redir_tgt;
    logic        prev_redir;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], 16'h5A5A};
    endfunction

    task automatic clear_model();
        pend_addr.delete(); pend_due.delete(); exp_q.delete();
        pop_pc.delete(); pop_cyc.delete();
        exp_pc = 64'h0; cyc = 0; last_due = -1;
        stall_exp = 0; flush_exp = 0; prev_redir = 1'b0;
    endtask

    // Assert reset right away, check the reset outputs, then release just after a rising edge.
    task automatic apply_reset();
        reset_n = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; pcsrc = 1'b0; ready = 1'b0;
        clear_model();
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 64'h0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock cycle: drive on the falling edge, observe at +1, then account for the next rising edge.
    task automatic step();
        int due;
        logic [95:0] e;
        @(negedge clk);
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = mk_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        gnt = gnt_en; ready = ready_en; pcsrc = redir_now; branch = redir_tgt;
        #1;
        if (prev_redir) chk("post_redirect_valid", valid, 0);
        if (redir_now)  chk("redirect_req", req, 0);
        if (!valid) stall_exp++;
        if (redir_now) flush_exp++;
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_with_empty_sb", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pc_D", pc, e[95:32]);
                chk("instr_D", instr, e[31:0]);
                pop_pc.push_back(pc);
                pop_cyc.push_back(cyc);
            end
        end
        if (req && gnt) begin
            chk("imem_addr", addr, exp_pc);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            pend_addr.push_back(addr);
            pend_due.push_back(due);
            exp_q.push_back({exp_pc, mk_word(exp_pc)});
            exp_pc = exp_pc + 64'd4;
        end
        if (redir_now) begin
            exp_q.delete();
            exp_pc = redir_tgt;
        end
        prev_redir = redir_now;
        cyc++;
    endtask

    task automatic drain();
        int n;
        gnt_en = 1'b0; ready_en = 1'b1; redir_now = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || pend_addr.size() != 0) && n < 60) begin
            step();
            n++;
        end
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // The N=8 instance checks that the PC wraps from 0xFC through 0x00 to 0x04.
    task automatic run_small();
        logic       g_prev;
        logic [7:0] a_prev;
        logic [7:0] got_pc[$];
        logic [31:0] got_in[$];
        s_rst_n = 1'b0; s_rv = 1'b0; s_rd = '0;
        g_prev = 1'b0; a_prev = '0;
        @(posedge clk); #1;
        chk("small_rst_addr", 64'(s_addr), 64'hFC);
        chk("small_rst_req", s_req, 0);
        s_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_rv = g_prev;
            s_rd = {24'h0, a_prev} ^ 32'hBEEF0000;
            #1;
            if (s_valid) begin
                got_pc.push_back(s_pc);
                got_in.push_back(s_instr);
            end
            g_prev = s_req;
            a_prev = s_addr;
        end
        chk("small_pops", 64'(got_pc.size() >= 3), 64'd1);
        if (got_pc.size() >= 3) begin
            chk("small_pc0", 64'(got_pc[0]), 64'hFC);
            chk("small_pc1", 64'(got_pc[1]), 64'h00);
            chk("small_pc2", 64'(got_pc[2]), 64'h04);
            chk("small_instr0", 64'(got_in[0]), 64'hBEEF00FC);
            chk("small_instr1", 64'(got_in[1]), 64'hBEEF0000);
        end
    endtask

    initial begin
        logic [63:0] sv_addr;
        logic        sv_valid;
        logic [63:0] sv_pc;
        reset_n = 1'b0; pcsrc = 1'b0; branch = '0; gnt = 1'b0;
        rvalid = 1'b0; rdata = '0; ready = 1'b0;
        gnt_en = 1'b1; ready_en = 1'b1; redir_now = 1'b0; redir_tgt = '0; lat = 1;
        clear_model();

        run_small();

        // Test 1: streaming with back-to-back delivery
        gnt_en = 1'b1; ready_en = 1'b1; lat = 1;
        apply_reset();
        repeat (8) step();
        chk("t1_pops", 64'(pop_pc.size() >= 4), 64'd1);
        if (pop_pc.size() >= 4) begin
            chk("t1_latency", 64'(pop_cyc[0]), 64'd2);
            for (int i = 0; i < 4; i++) begin
                chk("t1_pc_seq", pop_pc[i], 64'(4 * i));
                chk("t1_consecutive", 64'(pop_cyc[i]), 64'(pop_cyc[0] + i));
            end
        end

        // Test 2: decode stalled, so the queue fills and requests stop
        ready_en = 1'b0;
        apply_reset();
        repeat (8) step();
        chk("t2_req_off", req, 0);
        chk("t2_addr_hold", addr, 64'h10);
        chk("t2_valid", valid, 1);
        chk("t2_head_pc", pc, 64'h0);
        ready_en = 1'b1;
        repeat (12) step();
        chk("t2_drain_first", pop_pc[0], 64'h0);

        // Test 3: redirect with two requests outstanding
        lat = 3; gnt_en = 1'b1; ready_en = 1'b1;
        apply_reset();
        repeat (2) step();
        chk("t3_two_pending", 64'(pend_addr.size()), 64'd2);
        redir_now = 1'b1; redir_tgt = 64'h100;
        step();
        redir_now = 1'b0;
        pop_pc.delete();
        repeat (14) step();
        chk("t3_first_pop", 64'(pop_pc.size() >= 1), 64'd1);
        if (pop_pc.size() >= 1) chk("t3_first_pc", pop_pc[0], 64'h100);
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        chk("t7_flush_cnt", 64'(flush_cnt), 64'(flush_exp));
        chk("t7_stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif

        // Redirect while the queue holds words
        lat = 1;
        repeat (4) step();
        redir_now = 1'b1; redir_tgt = 64'h2000;
        step();
        redir_now = 1'b0;
        repeat (10) step();

        // Test 4: no grants, so address, valid and head stay put
        gnt_en = 1'b0; ready_en = 1'b0;
        repeat (4) step();
        sv_addr = addr; sv_valid = valid; sv_pc = pc;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_addr_stable", addr, sv_addr);
            chk("t4_valid_stable", valid, sv_valid);
            chk("t4_head_stable", pc, sv_pc);
        end
        gnt_en = 1'b1; ready_en = 1'b1;
        repeat (6) step();

        // Random traffic with occasional redirects
        for (int i = 0; i < 300; i++) begin
            gnt_en   = ($urandom_range(3, 0) != 0);
            ready_en = ($urandom_range(9, 0) < 7);
            lat      = $urandom_range(3, 1);
            redir_now = ($urandom_range(24, 0) == 0);
            redir_tgt = {$urandom, $urandom} & ~64'h3;
            step();
        end
        redir_now = 1'b0;
        drain();
`ifdef FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        chk("rand_flush_cnt", 64'(flush_cnt), 64'(flush_exp));
        chk("rand_stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif

        // Test 6: asynchronous reset in the middle of a stream
        gnt_en = 1'b1; ready_en = 1'b1; lat = 1;
        repeat (6) step();
        chk("t6_pre_valid", valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", valid, 0);
        chk("t6_async_req", req, 0);
        chk("t6_async_addr", addr, 64'h0);
        apply_reset();
        repeat (8) step();
        chk("t6_restart_pops", 64'(pop_pc.size() >= 1), 64'd1);
        if (pop_pc.size() >= 1) chk("t6_restart_pc", pop_pc[0], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
